// File: rtl/key_schedule_gen_if.sv
// Round-key schedule bus: start/key request from the key registers, keyed stream to the cipher core.
// master = schedule generator side, slave = requester/consumer side.
interface key_schedule_gen_if #(
  parameter int KEY_W = 64,
  parameter int IDX_W = 4
);
  logic             start;
  logic             mode;
  logic [0:KEY_W-1] master_key;
  logic [0:KEY_W-1] baby_key;
  logic [0:KEY_W-1] rk_data;
  logic [IDX_W-1:0] rk_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             busy;
  logic             done;
  logic [0:KEY_W-1] final_key;

  modport master (
    input  start, mode, master_key, baby_key, rk_ready,
    output rk_data, rk_idx, rk_valid, busy, done, final_key
  );

  modport slave (
    output start, mode, master_key, baby_key, rk_ready,
    input  rk_data, rk_idx, rk_valid, busy, done, final_key
  );
endinterface

// File: rtl/key_schedule_gen.sv
// Sequential round-key generator: seeds from master_key ^ baby_key and streams ROUNDS keys.
// First key two cycles after start, then one key per cycle; keys hold while rk_ready is low.
module key_schedule_gen #(
  parameter int KEY_W  = 64,
  parameter int ROUNDS = 16,
  parameter int ROT    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  key_schedule_gen_if.master ks
);
  localparam int IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {IDLE, SEED, EMIT, DONE} state_t;

  state_t           state;
  logic [0:KEY_W-1] seed_q;
  logic [0:KEY_W-1] baby_q;
  logic             mode_q;

  // Rotate via a doubled word so ROT=0 needs no special case.
  function automatic logic [0:KEY_W-1] mix(input logic [0:KEY_W-1] k,
                                           input logic [IDX_W-1:0] i);
    logic [0:2*KEY_W-1] kk;
    logic [0:KEY_W-1]   r;
    kk = {k, k} << ROT;
    r  = kk[0:KEY_W-1];
    if (mode_q) mix = r + baby_q + {{(KEY_W-IDX_W){1'b0}}, i};
    else        mix = r ^ baby_q;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      seed_q       <= '0;
      baby_q       <= '0;
      mode_q       <= 1'b0;
      ks.rk_data   <= '0;
      ks.rk_idx    <= '0;
      ks.rk_valid  <= 1'b0;
      ks.busy      <= 1'b0;
      ks.done      <= 1'b0;
      ks.final_key <= '0;
    end else begin
      case (state)
        IDLE: begin
          ks.done <= 1'b0;
          if (ks.start) begin
            seed_q  <= ks.master_key ^ ks.baby_key;
            baby_q  <= ks.baby_key;
            mode_q  <= ks.mode;
            ks.busy <= 1'b1;
            state   <= SEED;
          end
        end
        SEED: begin
          ks.rk_data  <= mix(seed_q, '0);
          ks.rk_idx   <= '0;
          ks.rk_valid <= 1'b1;
          state       <= EMIT;
        end
        EMIT: begin
          if (ks.rk_valid && ks.rk_ready) begin
            if (ks.rk_idx == IDX_W'(ROUNDS - 1)) begin
              ks.final_key <= ks.rk_data;
              ks.rk_valid  <= 1'b0;
              ks.done      <= 1'b1;
              state        <= DONE;
            end else begin
              ks.rk_data <= mix(ks.rk_data, ks.rk_idx + 1'b1);
              ks.rk_idx  <= ks.rk_idx + 1'b1;
            end
          end
        end
        DONE: begin
          ks.done <= 1'b0;
          ks.busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_schedule_gen.sv
// Directed bench for key_schedule_gen across three parameter sets.
module tb_key_schedule_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  localparam logic [63:0] MK = 64'h617859626A636431;
  localparam logic [63:0] BK = 64'h426162656967796C;

  always #5 clk = ~clk;

  key_schedule_gen_if #(.KEY_W(64), .IDX_W(1)) ia ();
  key_schedule_gen_if #(.KEY_W(64), .IDX_W(1)) ib ();
  key_schedule_gen_if #(.KEY_W(64), .IDX_W(4)) ic ();

  key_schedule_gen #(.KEY_W(64), .ROUNDS(2),  .ROT(0)) dut_a (.clk(clk), .rst_n(rst_n), .ks(ia));
  key_schedule_gen #(.KEY_W(64), .ROUNDS(1),  .ROT(0)) dut_b (.clk(clk), .rst_n(rst_n), .ks(ib));
  key_schedule_gen #(.KEY_W(64), .ROUNDS(16), .ROT(1)) dut_c (.clk(clk), .rst_n(rst_n), .ks(ic));

  // Reference round function for ROT=1, 64-bit keys.
  function automatic logic [63:0] fm(input logic [63:0] k, input logic [63:0] b,
                                     input logic md, input int i);
    logic [63:0] r;
    r = {k[62:0], k[63]};
    return md ? (r + b + 64'(i)) : (r ^ b);
  endfunction

  task automatic test_reset();
    #2;
    tests++;
    if ({ic.rk_valid, ic.rk_idx, ic.rk_data, ic.busy, ic.done, ic.final_key} !== '0) begin
      fails++; $display("FAIL reset_c: got v=%b i=%0d d=%h b=%b dn=%b f=%h want all 0",
                        ic.rk_valid, ic.rk_idx, ic.rk_data, ic.busy, ic.done, ic.final_key);
    end
    tests++;
    if ({ia.rk_valid, ia.busy, ia.done, ia.final_key, ib.rk_data} !== '0) begin
      fails++; $display("FAIL reset_ab: got a.v=%b a.b=%b a.dn=%b a.f=%h b.d=%h want 0",
                        ia.rk_valid, ia.busy, ia.done, ia.final_key, ib.rk_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_xor_two_rounds();
    ia.mode = 1'b0; ia.master_key = MK; ia.baby_key = BK; ia.rk_ready = 1'b1; ia.start = 1'b1;
    @(posedge clk); #1;
    ia.start = 1'b0;
    tests++;
    if (ia.busy !== 1'b1 || ia.rk_valid !== 1'b0) begin
      fails++; $display("FAIL t1_start: got busy=%b valid=%b want 1 0", ia.busy, ia.rk_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (ia.rk_valid !== 1'b1 || ia.rk_idx !== 1'b0 || ia.rk_data !== 64'h617859626A636431) begin
      fails++; $display("FAIL t1_rk0: got v=%b i=%0d d=%h want 1 0 617859626a636431",
                        ia.rk_valid, ia.rk_idx, ia.rk_data);
    end
    @(posedge clk); #1;
    tests++;
    if (ia.rk_valid !== 1'b1 || ia.rk_idx !== 1'b1 || ia.rk_data !== 64'h23193B0703041D5D) begin
      fails++; $display("FAIL t1_rk1: got v=%b i=%0d d=%h want 1 1 23193b0703041d5d",
                        ia.rk_valid, ia.rk_idx, ia.rk_data);
    end
    @(posedge clk); #1;
    tests++;
    if (ia.done !== 1'b1 || ia.rk_valid !== 1'b0 || ia.final_key !== 64'h23193B0703041D5D) begin
      fails++; $display("FAIL t1_done: got done=%b v=%b f=%h want 1 0 23193b0703041d5d",
                        ia.done, ia.rk_valid, ia.final_key);
    end
    @(posedge clk); #1;
    tests++;
    if (ia.done !== 1'b0 || ia.busy !== 1'b0) begin
      fails++; $display("FAIL t1_after: got done=%b busy=%b want 0 0", ia.done, ia.busy);
    end
  endtask

  task automatic test_add_single_round();
    ib.mode = 1'b1; ib.master_key = MK; ib.baby_key = BK; ib.rk_ready = 1'b1; ib.start = 1'b1;
    @(posedge clk); #1;
    ib.start = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (ib.rk_valid !== 1'b1 || ib.rk_idx !== 1'b0 || ib.rk_data !== 64'h657A9D6C6C6B96C9) begin
      fails++; $display("FAIL t2_rk0: got v=%b i=%0d d=%h want 1 0 657a9d6c6c6b96c9",
                        ib.rk_valid, ib.rk_idx, ib.rk_data);
    end
    @(posedge clk); #1;
    tests++;
    if (ib.done !== 1'b1 || ib.final_key !== 64'h657A9D6C6C6B96C9) begin
      fails++; $display("FAIL t2_done: got done=%b f=%h want 1 657a9d6c6c6b96c9",
                        ib.done, ib.final_key);
    end
    @(posedge clk); #1;
    tests++;
    if (ib.done !== 1'b0 || ib.busy !== 1'b0) begin
      fails++; $display("FAIL t2_after: got done=%b busy=%b want 0 0", ib.done, ib.busy);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] m, b, exp_k, last_k;
    int n, stall;
    m = 64'h0123456789ABCDEF; b = 64'hFEDCBA9876543210;
    exp_k = fm(m ^ b, b, 1'b1, 0); last_k = '0; n = 0; stall = 0;
    ic.mode = 1'b1; ic.master_key = m; ic.baby_key = b; ic.rk_ready = 1'b0; ic.start = 1'b1;
    @(posedge clk); #1;
    ic.start = 1'b0;
    for (int cyc = 0; cyc < 100 && n < 16; cyc++) begin
      @(posedge clk); #1;
      tests++;
      if (ic.done !== 1'b0) begin
        fails++; $display("FAIL t3_early_done: got done=%b at key %0d want 0", ic.done, n);
      end
      if (ic.rk_valid) begin
        tests++;
        if (ic.rk_data !== exp_k || ic.rk_idx !== 4'(n)) begin
          fails++; $display("FAIL t3_key: got i=%0d d=%h want i=%0d d=%h",
                            ic.rk_idx, ic.rk_data, n, exp_k);
        end
        if (n == 3 && stall < 5) begin
          ic.rk_ready = 1'b0; stall++;
        end else begin
          ic.rk_ready = 1'b1;
          last_k = exp_k; n++;
          exp_k = fm(exp_k, b, 1'b1, n);
        end
      end
    end
    tests++;
    if (n != 16 || stall != 5) begin
      fails++; $display("FAIL t3_count: got %0d keys %0d stalls want 16 5", n, stall);
    end
    @(posedge clk); #1;
    tests++;
    if (ic.done !== 1'b1 || ic.rk_valid !== 1'b0 || ic.final_key !== last_k) begin
      fails++; $display("FAIL t3_done: got done=%b v=%b f=%h want 1 0 %h",
                        ic.done, ic.rk_valid, ic.final_key, last_k);
    end
    @(posedge clk); #1;
    tests++;
    if (ic.done !== 1'b0 || ic.busy !== 1'b0) begin
      fails++; $display("FAIL t3_after: got done=%b busy=%b want 0 0", ic.done, ic.busy);
    end
  endtask

  // master=0, baby=1, XOR, ROT=1: key i is (1 << (i+2)) - 1.
  // inject: 0 none, 1 stray start at idx 5, 2 reset at idx 7.
  task automatic run_stream(input string tag, input int inject);
    logic [63:0] exp_k;
    ic.mode = 1'b0; ic.master_key = 64'd0; ic.baby_key = 64'd1; ic.rk_ready = 1'b1; ic.start = 1'b1;
    @(posedge clk); #1;
    ic.start = 1'b0;
    tests++;
    if (ic.busy !== 1'b1 || ic.rk_valid !== 1'b0) begin
      fails++; $display("FAIL %s_start: got busy=%b valid=%b want 1 0", tag, ic.busy, ic.rk_valid);
    end
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      exp_k = (64'd1 << (i + 2)) - 64'd1;
      tests++;
      if (ic.rk_valid !== 1'b1 || ic.rk_idx !== 4'(i) || ic.rk_data !== exp_k || ic.done !== 1'b0) begin
        fails++; $display("FAIL %s_key: got v=%b i=%0d d=%h dn=%b want 1 %0d %h 0",
                          tag, ic.rk_valid, ic.rk_idx, ic.rk_data, ic.done, i, exp_k);
      end
      if (inject == 1 && i == 5) begin
        ic.start = 1'b1; ic.mode = 1'b1;
        ic.master_key = 64'hDEADBEEFCAFEF00D; ic.baby_key = 64'h1122334455667788;
      end
      if (inject == 1 && i == 6) ic.start = 1'b0;
      if (inject == 2 && i == 7) begin
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ic.rk_valid, ic.rk_idx, ic.rk_data, ic.busy, ic.done, ic.final_key} !== '0) begin
          fails++; $display("FAIL %s_rst: got v=%b i=%0d d=%h b=%b dn=%b f=%h want all 0", tag,
                            ic.rk_valid, ic.rk_idx, ic.rk_data, ic.busy, ic.done, ic.final_key);
        end
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          tests++;
          if (ic.done !== 1'b0 || ic.rk_valid !== 1'b0) begin
            fails++; $display("FAIL %s_rst_hold: got done=%b valid=%b want 0 0", tag, ic.done, ic.rk_valid);
          end
        end
        rst_n = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    tests++;
    if (ic.done !== 1'b1 || ic.rk_valid !== 1'b0 || ic.final_key !== 64'h1FFFF) begin
      fails++; $display("FAIL %s_done: got done=%b v=%b f=%h want 1 0 1ffff",
                        tag, ic.done, ic.rk_valid, ic.final_key);
    end
    @(posedge clk); #1;
    tests++;
    if (ic.done !== 1'b0 || ic.busy !== 1'b0) begin
      fails++; $display("FAIL %s_after: got done=%b busy=%b want 0 0", tag, ic.done, ic.busy);
    end
    @(posedge clk); #1;
    tests++;
    if (ic.busy !== 1'b0 || ic.rk_valid !== 1'b0) begin
      fails++; $display("FAIL %s_idle: got busy=%b valid=%b want 0 0", tag, ic.busy, ic.rk_valid);
    end
  endtask

  task automatic test_back_to_back();
    run_stream("t4", 0);
  endtask

  task automatic test_start_ignored();
    run_stream("t5", 1);
  endtask

  task automatic test_reset_abort();
    run_stream("t6", 2);
    @(posedge clk); #1;
    run_stream("t6_restart", 0);
  endtask

  initial begin
    ia.start = 1'b0; ia.mode = 1'b0; ia.master_key = '0; ia.baby_key = '0; ia.rk_ready = 1'b0;
    ib.start = 1'b0; ib.mode = 1'b0; ib.master_key = '0; ib.baby_key = '0; ib.rk_ready = 1'b0;
    ic.start = 1'b0; ic.mode = 1'b0; ic.master_key = '0; ic.baby_key = '0; ic.rk_ready = 1'b0;
    test_reset();
    test_xor_two_rounds();
    test_add_single_round();
    test_backpressure();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
